glitch_pulse_seq: RTL and testbench
===================================

// Module: glitch_pulse_seq
// PURPOSE
//   Parametrised multi-pulse glitch sequencer, the successor to the single-shot glitch path.
//   On an armed, qualified trigger edge it waits a programmable delay, then emits a train of
//   COUNT pulses with programmable width and gap. Arming supports a timeout and abort.
//   Sits between the UART command decoder, which drives the config and arm/abort strobes,
//   and the pulse / pulse-enable output pins.
// PARAMETERS
//   DELAY_W      24  width of trigger-to-first-pulse delay, in clk cycles
//   WIDTH_W      16  width of the pulse-width and gap fields, in clk cycles
//   CNT_W         8  width of the pulse-count field
//   TO_W         32  width of the arm-timeout field, in clk cycles
//   SYNC_STAGES   2  trigger synchroniser depth (>=2)
// PORTS
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous reset, active low
//   arm_i        in   1        1-cycle strobe: latch config, enter ARMED (ignored unless IDLE)
//   abort_i      in   1        level; forces IDLE, has priority over all else
//   trigger_i    in   1        asynchronous target trigger pin
//   edge_sel_i   in   2        00 rise, 01 fall, 10 either, 11 high level
//   delay_i      in   DELAY_W  cycles from recognised trigger to first pulse
//   width_i      in   WIDTH_W  pulse high time (0 treated as 1)
//   gap_i        in   WIDTH_W  low time between pulses (0 treated as 1)
//   count_i      in   CNT_W    pulses per trigger (0 treated as 1)
//   timeout_i    in   TO_W     ARMED timeout in cycles; 0 = wait forever
//   pulse_o      out  1        glitch pulse, registered, glitch-free
//   pulse_en_o   out  1        high ARMED..end of last pulse (drives glitch-switch enable)
//   armed_o      out  1        high in ARMED
//   busy_o       out  1        high in any state except IDLE
//   done_o       out  1        1-cycle strobe after the last pulse falls
//   timeout_o    out  1        1-cycle strobe when the ARMED timeout expires
// BEHAVIOUR
//   - Reset: all outputs 0, FSM IDLE, counters 0, synchroniser flops 0.
//   - Config is latched on arm_i in IDLE; changes to *_i while busy have no effect.
//   - The trigger passes through SYNC_STAGES flops plus one history flop. Edge qualification
//     uses only synchronised values. A level present at arm time does NOT count as an edge.
//   - FSM: IDLE -arm-> ARMED -trig-> DELAY -> PULSE <-> GAP -> DONE -> IDLE.
//       ARMED: wait for a qualified trigger. If timeout_i!=0 and timeout_i cycles elapse
//              first -> timeout_o=1 for 1 cycle, go IDLE.
//       DELAY: count delay_i cycles (0 = no wait).
//       PULSE: pulse_o=1 for width cycles. On the last pulse -> DONE, else -> GAP.
//       GAP:   pulse_o=0 for gap cycles -> PULSE.
//       DONE:  done_o=1 for one cycle -> IDLE.
//   - Latency: if trigger_i changes before posedge k, pulse_o first rises at posedge
//     k+SYNC_STAGES+1+delay. It stays high exactly width cycles.
//   - Period of the train = width+gap. Total pulses = max(count,1). Counters saturate, never wrap.
//   - pulse_en_o rises with armed_o and falls together with the last pulse_o fall.
//   - abort_i: on the next posedge, FSM is IDLE and all outputs are 0, including mid-pulse.
//     No done_o or timeout_o is emitted.
//   - Simultaneous timeout expiry and qualified trigger in the same cycle: trigger wins.
//   - Further triggers during DELAY/PULSE/GAP are ignored (no retrigger).
//   - Simultaneous arm_i and abort_i: abort wins, FSM stays IDLE.
//   - Async reset mid-train drops pulse_o immediately. Sequencing restarts only on a new arm.
// TESTING
//   1. rst_n low mid-pulse (width=100) -> pulse_o, busy_o, pulse_en_o 0 asynchronously.
//      Stays IDLE after release.
//   2. arm: delay=10, width=5, gap=3, count=1, edge=rise. Trigger rises before posedge k ->
//      pulse_o high posedges k+13..k+17, done_o at k+18.
//   3. count=4, width=2, gap=0 -> four 2-cycle pulses with 1-cycle gaps,
//      single done_o, pulse_en_o falls with the 4th pulse.
//   4. timeout=50, no trigger -> timeout_o at cycle 50 after arm, then IDLE.
//      Later trigger edges produce no pulse.
//   5. edge=fall with trigger already high at arm -> no pulse. Fall later -> pulse.
//      edge=11 with trigger high at arm -> fires only after the first synchronised high sample.
//   6. abort_i asserted during 3rd of 5 pulses -> pulse_o 0 next cycle, no done_o.
//      Re-arm works; arm_i while busy is ignored.

Source files
------------

// File: rtl/glitch_pulse_seq.sv
// glitch_pulse_seq: multi-pulse glitch sequencer.
// When armed, a qualified trigger edge starts a programmable delay, followed by a
// train of pulses with programmable width and gap. Config is captured at arm time,
// so the command decoder can rewrite its registers freely while a train runs.
// All outputs are driven straight from flops, so the glitch-switch pins never see
// decode hazards.
module glitch_pulse_seq #(
  parameter int DELAY_W     = 24,
  parameter int WIDTH_W     = 16,
  parameter int CNT_W       = 8,
  parameter int TO_W        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               trigger_i,
  input  logic [1:0]         edge_sel_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [WIDTH_W-1:0] width_i,
  input  logic [WIDTH_W-1:0] gap_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [TO_W-1:0]    timeout_i,
  output logic               pulse_o,
  output logic               pulse_en_o,
  output logic               armed_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);

  // One counter serves the delay, pulse-width and gap phases, so it must hold
  // the wider of those two fields.
  localparam int CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] EDGE_RISE  = 2'b00;
  localparam logic [1:0] EDGE_FALL  = 2'b01;
  localparam logic [1:0] EDGE_BOTH  = 2'b10;

  // Trigger synchroniser and history.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   trig_s;
  logic                   trig_hit;

  // Configuration captured at arm time. Width and gap are stored minus one so
  // that the phase counter compares directly against its final value; zero
  // inputs map to a stored zero, i.e. one cycle.
  logic [1:0]             edge_sel_reg;
  logic [DELAY_W-1:0]     delay_reg;
  logic [WIDTH_W-1:0]     width_m1_reg;
  logic [WIDTH_W-1:0]     gap_m1_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [TO_W-1:0]        timeout_reg;

  logic [WIDTH_W-1:0]     width_m1_next;
  logic [WIDTH_W-1:0]     gap_m1_next;
  logic [CNT_W-1:0]       count_eff_next;

  // FSM state and counters.
  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic [CW-1:0]          cnt_reg;
  logic [CW-1:0]          cnt_next;
  logic [TO_W-1:0]        to_cnt_reg;
  logic [TO_W-1:0]        to_cnt_next;
  logic [CNT_W-1:0]       pulses_reg;
  logic [CNT_W-1:0]       pulses_next;
  logic                   latch_cfg;
  logic                   timeout_fire;

  // Registered outputs.
  logic                   pulse_reg;
  logic                   pulse_en_reg;
  logic                   armed_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   timeout_reg_o;

  assign trig_s = sync_reg[SYNC_STAGES-1];

  // Shift the raw trigger through the synchroniser and keep one history sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], trigger_i};
      hist_reg <= trig_s;
    end
  end

  // Qualify the synchronised trigger against the selected edge/level mode.
  // A level already present when arming gives no edge because history tracks it.
  always_comb begin
    trig_hit = 1'b0;
    case (edge_sel_reg)
      EDGE_RISE: trig_hit = trig_s & ~hist_reg;
      EDGE_FALL: trig_hit = ~trig_s & hist_reg;
      EDGE_BOTH: trig_hit = trig_s ^ hist_reg;
      default:   trig_hit = trig_s;
    endcase
  end

  // Normalise the zero-means-one fields before they are captured.
  always_comb begin
    width_m1_next  = (width_i == '0) ? '0 : width_i - WIDTH_W'(1);
    gap_m1_next    = (gap_i == '0)   ? '0 : gap_i - WIDTH_W'(1);
    count_eff_next = (count_i == '0) ? CNT_W'(1) : count_i;
  end

  // Sequencer next-state logic; abort overrides every other decision.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    to_cnt_next  = to_cnt_reg;
    pulses_next  = pulses_reg;
    latch_cfg    = 1'b0;
    timeout_fire = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (arm_i) begin
          state_next  = S_ARMED;
          latch_cfg   = 1'b1;
          to_cnt_next = '0;
        end
      end

      S_ARMED: begin
        // Trigger is tested first so it wins over a coincident timeout.
        if (trig_hit) begin
          state_next  = S_DELAY;
          cnt_next    = '0;
          pulses_next = '0;
        end else if ((timeout_reg != '0) && (to_cnt_reg >= timeout_reg - TO_W'(1))) begin
          state_next   = S_IDLE;
          timeout_fire = 1'b1;
        end else if (to_cnt_reg != '1) begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end

      S_DELAY: begin
        // One cycle is always spent here, giving a fixed pipeline latency even
        // for a zero delay.
        if (cnt_reg >= CW'(delay_reg)) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      S_PULSE: begin
        if (cnt_reg >= CW'(width_m1_reg)) begin
          cnt_next = '0;
          if (pulses_reg >= count_reg - CNT_W'(1)) begin
            state_next = S_DONE;
          end else begin
            state_next = S_GAP;
            if (pulses_reg != '1) begin
              pulses_next = pulses_reg + CNT_W'(1);
            end
          end
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_reg >= CW'(gap_m1_reg)) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort_i) begin
      state_next   = S_IDLE;
      latch_cfg    = 1'b0;
      timeout_fire = 1'b0;
    end
  end

  // Advance the FSM and its counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      to_cnt_reg <= '0;
      pulses_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      to_cnt_reg <= to_cnt_next;
      pulses_reg <= pulses_next;
    end
  end

  // Capture configuration only on an accepted arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_sel_reg <= 2'b00;
      delay_reg    <= '0;
      width_m1_reg <= '0;
      gap_m1_reg   <= '0;
      count_reg    <= CNT_W'(1);
      timeout_reg  <= '0;
    end else if (latch_cfg) begin
      edge_sel_reg <= edge_sel_i;
      delay_reg    <= delay_i;
      width_m1_reg <= width_m1_next;
      gap_m1_reg   <= gap_m1_next;
      count_reg    <= count_eff_next;
      timeout_reg  <= timeout_i;
    end
  end

  // Outputs are decoded from the next state and registered, so they change
  // together with the state they describe and are free of decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_reg     <= 1'b0;
      pulse_en_reg  <= 1'b0;
      armed_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg_o <= 1'b0;
    end else begin
      pulse_reg     <= (state_next == S_PULSE);
      pulse_en_reg  <= (state_next == S_ARMED) || (state_next == S_DELAY) ||
                       (state_next == S_PULSE) || (state_next == S_GAP);
      armed_reg     <= (state_next == S_ARMED);
      busy_reg      <= (state_next != S_IDLE);
      done_reg      <= (state_next == S_DONE);
      timeout_reg_o <= timeout_fire;
    end
  end

  assign pulse_o    = pulse_reg;
  assign pulse_en_o = pulse_en_reg;
  assign armed_o    = armed_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign timeout_o  = timeout_reg_o;

endmodule

// File: tb/tb_glitch_pulse_seq.sv
// Directed testbench for glitch_pulse_seq. Expected waveforms are hand-computed
// bit vectors indexed by posedges after the trigger change (bit 0 = first edge).
module tb_glitch_pulse_seq;

  localparam int DELAY_W     = 24;
  localparam int WIDTH_W     = 16;
  localparam int CNT_W       = 8;
  localparam int TO_W        = 32;
  localparam int SYNC_STAGES = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               arm_i;
  logic               abort_i;
  logic               trigger_i;
  logic [1:0]         edge_sel_i;
  logic [DELAY_W-1:0] delay_i;
  logic [WIDTH_W-1:0] width_i;
  logic [WIDTH_W-1:0] gap_i;
  logic [CNT_W-1:0]   count_i;
  logic [TO_W-1:0]    timeout_i;
  logic               pulse_o;
  logic               pulse_en_o;
  logic               armed_o;
  logic               busy_o;
  logic               done_o;
  logic               timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  glitch_pulse_seq #(
    .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W), .CNT_W(CNT_W),
    .TO_W(TO_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i),
    .trigger_i(trigger_i), .edge_sel_i(edge_sel_i), .delay_i(delay_i),
    .width_i(width_i), .gap_i(gap_i), .count_i(count_i), .timeout_i(timeout_i),
    .pulse_o(pulse_o), .pulse_en_o(pulse_en_o), .armed_o(armed_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present config and a one-cycle arm strobe; returns just after the arm edge.
  task automatic do_arm(input logic [1:0] es, input int d, input int w, input int g,
                        input int c, input int to);
    edge_sel_i = es;
    delay_i    = DELAY_W'(d);
    width_i    = WIDTH_W'(w);
    gap_i      = WIDTH_W'(g);
    count_i    = CNT_W'(c);
    timeout_i  = TO_W'(to);
    arm_i      = 1'b1;
    tick();
    arm_i      = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] p, output logic [31:0] dn,
                         output logic [31:0] en, output logic [31:0] bz);
    p = '0; dn = '0; en = '0; bz = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      p[i]  = pulse_o;
      dn[i] = done_o;
      en[i] = pulse_en_o;
      bz[i] = busy_o;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
    edge_sel_i = 2'b00; delay_i = '0; width_i = '0; gap_i = '0;
    count_i = '0; timeout_i = '0;
    ticks(3);
    n_cmp++;
    if ({pulse_o, pulse_en_o, armed_o, busy_o, done_o, timeout_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {pulse_o, pulse_en_o, armed_o, busy_o, done_o, timeout_o});
    end
    rst_n = 1'b1;
    ticks(3);
    n_cmp++;
    if ({pulse_o, pulse_en_o, armed_o, busy_o, done_o, timeout_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %b expected 000000",
               {pulse_o, pulse_en_o, armed_o, busy_o, done_o, timeout_o});
    end
    $display("test_reset done");
  endtask

  task automatic test_single_pulse();
    logic [31:0] p, dn, en, bz;
    trigger_i = 1'b0;
    ticks(3);
    do_arm(2'b00, 10, 5, 3, 1, 0);
    n_cmp++;
    if ({armed_o, pulse_en_o, busy_o} !== 3'b111) begin
      n_bad++;
      $display("FAIL arm_flags: got %b expected 111", {armed_o, pulse_en_o, busy_o});
    end
    ticks(3);
    trigger_i = 1'b1;
    capture(21, p, dn, en, bz);
    n_cmp++;
    if (p !== 32'h0003_E000) begin
      n_bad++; $display("FAIL single_pulse: got %h expected %h", p, 32'h0003_E000);
    end
    n_cmp++;
    if (dn !== 32'h0004_0000) begin
      n_bad++; $display("FAIL single_done: got %h expected %h", dn, 32'h0004_0000);
    end
    n_cmp++;
    if (en !== 32'h0003_FFFF) begin
      n_bad++; $display("FAIL single_pulse_en: got %h expected %h", en, 32'h0003_FFFF);
    end
    n_cmp++;
    if (bz !== 32'h0007_FFFF) begin
      n_bad++; $display("FAIL single_busy: got %h expected %h", bz, 32'h0007_FFFF);
    end
    trigger_i = 1'b0;
    ticks(3);
    $display("test_single_pulse done");
  endtask

  task automatic test_train();
    logic [31:0] p, dn, en, bz;
    do_arm(2'b00, 0, 2, 0, 4, 0);
    ticks(3);
    trigger_i = 1'b1;
    capture(20, p, dn, en, bz);
    n_cmp++;
    if (p !== 32'h0000_36D8) begin
      n_bad++; $display("FAIL train_pulse: got %h expected %h", p, 32'h0000_36D8);
    end
    n_cmp++;
    if (dn !== 32'h0000_4000) begin
      n_bad++; $display("FAIL train_done: got %h expected %h", dn, 32'h0000_4000);
    end
    n_cmp++;
    if (en !== 32'h0000_3FFF) begin
      n_bad++; $display("FAIL train_pulse_en: got %h expected %h", en, 32'h0000_3FFF);
    end
    trigger_i = 1'b0;
    ticks(3);
    $display("test_train done");
  endtask

  task automatic test_timeout();
    logic seen;
    trigger_i = 1'b0;
    do_arm(2'b00, 0, 1, 0, 1, 50);
    ticks(49);
    n_cmp++;
    if ({timeout_o, armed_o} !== 2'b01) begin
      n_bad++; $display("FAIL timeout_early: got %b expected 01", {timeout_o, armed_o});
    end
    tick();
    n_cmp++;
    if ({timeout_o, armed_o, busy_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL timeout_strobe: got %b expected 100", {timeout_o, armed_o, busy_o});
    end
    tick();
    n_cmp++;
    if (timeout_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_one_cycle: got %b expected 0", timeout_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trigger_i = 1'b1; tick(); seen |= pulse_o | busy_o; tick(); seen |= pulse_o | busy_o;
      trigger_i = 1'b0; tick(); seen |= pulse_o | busy_o; tick(); seen |= pulse_o | busy_o;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL timeout_then_trigger: got %b expected 0", seen);
    end
    $display("test_timeout done");
  endtask

  task automatic test_edge_modes();
    logic [31:0] p, dn, en, bz;
    trigger_i = 1'b1;
    ticks(5);
    do_arm(2'b01, 0, 1, 0, 1, 0);
    capture(15, p, dn, en, bz);
    n_cmp++;
    if ({p, armed_o} !== {32'h0, 1'b1}) begin
      n_bad++; $display("FAIL fall_level_at_arm: got %h/%b expected 0/1", p, armed_o);
    end
    trigger_i = 1'b0;
    capture(6, p, dn, en, bz);
    n_cmp++;
    if (p !== 32'h8) begin
      n_bad++; $display("FAIL fall_pulse: got %h expected %h", p, 32'h8);
    end
    n_cmp++;
    if (dn !== 32'h10) begin
      n_bad++; $display("FAIL fall_done: got %h expected %h", dn, 32'h10);
    end
    trigger_i = 1'b1;
    ticks(5);
    do_arm(2'b11, 0, 1, 0, 1, 0);
    capture(5, p, dn, en, bz);
    n_cmp++;
    if (p !== 32'h2) begin
      n_bad++; $display("FAIL level_pulse: got %h expected %h", p, 32'h2);
    end
    n_cmp++;
    if (dn !== 32'h4) begin
      n_bad++; $display("FAIL level_done: got %h expected %h", dn, 32'h4);
    end
    trigger_i = 1'b0;
    ticks(4);
    $display("test_edge_modes done");
  endtask

  task automatic test_abort_rearm();
    logic [31:0] p, dn, en, bz;
    logic        seen_done;
    int          hi_cycles, n_done, n_rise;
    logic        prev;
    do_arm(2'b00, 0, 4, 2, 5, 0);
    ticks(3);
    trigger_i = 1'b1;
    capture(17, p, dn, en, bz);
    n_cmp++;
    if (p !== 32'h0001_9E78) begin
      n_bad++; $display("FAIL abort_pre_train: got %h expected %h", p, 32'h0001_9E78);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++;
    if ({pulse_o, pulse_en_o, armed_o, busy_o, done_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: got %b expected 00000",
               {pulse_o, pulse_en_o, armed_o, busy_o, done_o});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_done |= done_o | pulse_o;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++; $display("FAIL abort_no_done: got %b expected 0", seen_done);
    end
    trigger_i = 1'b0;
    abort_i = 1'b1;
    do_arm(2'b00, 0, 1, 0, 1, 0);
    abort_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL arm_with_abort: got %b expected 0", busy_o);
    end
    ticks(3);
    do_arm(2'b00, 5, 1, 0, 1, 0);
    ticks(3);
    trigger_i = 1'b1;
    ticks(4);
    do_arm(2'b00, 0, 3, 0, 3, 0);
    hi_cycles = 0; n_done = 0; n_rise = 0; prev = pulse_o;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (pulse_o) hi_cycles++;
      if (done_o) n_done++;
      if (pulse_o && !prev) n_rise++;
      prev = pulse_o;
    end
    n_cmp++;
    if ({hi_cycles, n_rise, n_done} !== {32'd1, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL rearm_busy_arm: got hi=%0d rises=%0d done=%0d expected 1/1/1",
               hi_cycles, n_rise, n_done);
    end
    trigger_i = 1'b0;
    ticks(3);
    $display("test_abort_rearm done");
  endtask

  task automatic test_async_reset();
    logic seen;
    do_arm(2'b00, 0, 100, 0, 1, 0);
    ticks(3);
    trigger_i = 1'b1;
    ticks(10);
    n_cmp++;
    if (pulse_o !== 1'b1) begin
      n_bad++; $display("FAIL long_pulse_high: got %b expected 1", pulse_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pulse_o, busy_o, pulse_en_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset_drop: got %b expected 000", {pulse_o, busy_o, pulse_en_o});
    end
    ticks(2);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      trigger_i = ~trigger_i;
      tick();
      seen |= busy_o | pulse_en_o | pulse_o;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL reset_stays_idle: got %b expected 0", seen);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_train();
    test_timeout();
    test_edge_modes();
    test_abort_rearm();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
